// File: rtl/cbd_sampler_stream.sv
// Centred-binomial noise sampler: turns a PRF word stream into signed CBD(eta)
// coefficients, LANES per beat, for 1..MAX_POLY polynomials per run.
module cbd_sampler_stream #(
  parameter int IN_W     = 64,
  parameter int LANES    = 4,
  parameter int COEFF_W  = 8,
  parameter int MAX_POLY = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic                                      run_i,
  input  logic                                      eta_i,
  input  logic [$clog2(MAX_POLY+1)-1:0]             npoly_i,
  input  logic                                      in_valid_i,
  output logic                                      in_ready_o,
  input  logic [IN_W-1:0]                           in_data_i,
  output logic                                      coef_valid_o,
  input  logic                                      coef_ready_i,
  output logic [LANES*COEFF_W-1:0]                  coef_o,
  output logic [7:0]                                coef_idx_o,
  output logic [((MAX_POLY > 1) ? $clog2(MAX_POLY) : 1)-1:0] poly_idx_o,
  output logic                                      last_o,
  output logic                                      busy_o,
  output logic                                      done_o
);

  localparam int BUF_W   = IN_W + 6 * LANES;
  localparam int FILL_W  = $clog2(BUF_W + 1);
  localparam int WORDS_W = $clog2(1536 / IN_W + 1);
  localparam int NPOLY_W = $clog2(MAX_POLY + 1);
  localparam int PIDX_W  = (MAX_POLY > 1) ? $clog2(MAX_POLY) : 1;

  localparam logic [FILL_W-1:0]  CHUNK2_BITS = FILL_W'(4 * LANES);
  localparam logic [FILL_W-1:0]  CHUNK3_BITS = FILL_W'(6 * LANES);
  localparam logic [FILL_W-1:0]  WORD_BITS   = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0]  READY_MAX   = FILL_W'(BUF_W - IN_W);
  localparam logic [WORDS_W-1:0] WPP_ETA2    = WORDS_W'(1024 / IN_W);
  localparam logic [WORDS_W-1:0] WPP_ETA3    = WORDS_W'(1536 / IN_W);
  localparam logic [7:0]         LAST_IDX    = 8'(256 - LANES);
  localparam logic [7:0]         IDX_STEP    = 8'(LANES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]         state_r;
  logic               eta_r;
  logic [NPOLY_W-1:0] npoly_r;
  logic [BUF_W-1:0]   buf_r;
  logic [FILL_W-1:0]  fill_r;
  logic [WORDS_W-1:0] words_r;
  logic [7:0]         coef_idx_r;
  logic [PIDX_W-1:0]  poly_idx_r;

  logic                     sample_s;
  logic [FILL_W-1:0]        chunk_bits_s;
  logic [WORDS_W-1:0]       wpp_s;
  logic                     in_ready_s;
  logic                     coef_valid_s;
  logic                     poly_end_s;
  logic                     last_poly_s;
  logic                     accept_s;
  logic                     consume_s;
  logic [BUF_W-1:0]         shifted_s;
  logic [FILL_W-1:0]        fill_shift_s;
  logic [BUF_W-1:0]         buf_next_s;
  logic [FILL_W-1:0]        fill_next_s;
  logic [LANES*COEFF_W-1:0] coef_s;

  // One CBD coefficient: popcount of the low eta bits minus popcount of the high eta bits.
  function automatic logic [COEFF_W-1:0] cbd_coef(input logic [5:0] chunk, input logic eta3);
    logic [2:0]        pos;
    logic [2:0]        neg;
    logic signed [3:0] diff;
    if (eta3) begin
      pos = 3'(chunk[0]) + 3'(chunk[1]) + 3'(chunk[2]);
      neg = 3'(chunk[3]) + 3'(chunk[4]) + 3'(chunk[5]);
    end else begin
      pos = 3'(chunk[0]) + 3'(chunk[1]);
      neg = 3'(chunk[2]) + 3'(chunk[3]);
    end
    diff = $signed({1'b0, pos}) - $signed({1'b0, neg});
    return COEFF_W'(diff);
  endfunction

  // Handshake qualifiers; all derived from registered state only.
  always_comb begin
    sample_s     = (state_r == ST_SAMPLE);
    chunk_bits_s = eta_r ? CHUNK3_BITS : CHUNK2_BITS;
    wpp_s        = eta_r ? WPP_ETA3 : WPP_ETA2;
    in_ready_s   = sample_s && (fill_r <= READY_MAX) && (words_r < wpp_s);
    coef_valid_s = sample_s && (fill_r >= chunk_bits_s);
    poly_end_s   = (coef_idx_r == LAST_IDX);
    last_poly_s  = (NPOLY_W'(poly_idx_r) == (npoly_r - NPOLY_W'(1)));
    accept_s     = in_valid_i && in_ready_s;
    consume_s    = coef_valid_s && coef_ready_i;
  end

  // Buffer update: drop the consumed chunk first, then append the new word above the fill.
  always_comb begin
    shifted_s    = buf_r;
    fill_shift_s = fill_r;
    if (consume_s) begin
      shifted_s    = eta_r ? (buf_r >> (6 * LANES)) : (buf_r >> (4 * LANES));
      fill_shift_s = fill_r - chunk_bits_s;
    end else begin
      shifted_s    = buf_r;
      fill_shift_s = fill_r;
    end
    buf_next_s  = shifted_s;
    fill_next_s = fill_shift_s;
    if (accept_s) begin
      buf_next_s  = shifted_s | (BUF_W'(in_data_i) << fill_shift_s);
      fill_next_s = fill_shift_s + WORD_BITS;
    end else begin
      buf_next_s  = shifted_s;
      fill_next_s = fill_shift_s;
    end
  end

  // Lane k decodes chunk k from the bottom of the buffer.
  always_comb begin
    coef_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (eta_r) begin
        coef_s[k*COEFF_W +: COEFF_W] = cbd_coef(buf_r[6*k +: 6], 1'b1);
      end else begin
        coef_s[k*COEFF_W +: COEFF_W] = cbd_coef({2'b00, buf_r[4*k +: 4]}, 1'b0);
      end
    end
  end

  // Run control, bit buffer and beat/polynomial counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_IDLE;
      eta_r      <= 1'b0;
      npoly_r    <= '0;
      buf_r      <= '0;
      fill_r     <= '0;
      words_r    <= '0;
      coef_idx_r <= 8'd0;
      poly_idx_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run_i) begin
            eta_r      <= eta_i;
            npoly_r    <= npoly_i;
            buf_r      <= '0;
            fill_r     <= '0;
            words_r    <= '0;
            coef_idx_r <= 8'd0;
            poly_idx_r <= '0;
            state_r    <= (npoly_i != NPOLY_W'(0)) ? ST_SAMPLE : ST_FINISH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SAMPLE: begin
          buf_r  <= buf_next_s;
          fill_r <= fill_next_s;
          if (consume_s && poly_end_s) begin
            words_r <= '0;
          end else if (accept_s) begin
            words_r <= words_r + WORDS_W'(1);
          end else begin
            words_r <= words_r;
          end
          if (consume_s) begin
            if (poly_end_s) begin
              coef_idx_r <= 8'd0;
              if (last_poly_s) begin
                poly_idx_r <= '0;
                state_r    <= ST_FINISH;
              end else begin
                poly_idx_r <= poly_idx_r + PIDX_W'(1);
              end
            end else begin
              coef_idx_r <= coef_idx_r + IDX_STEP;
            end
          end else begin
            coef_idx_r <= coef_idx_r;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_s;
  assign coef_valid_o = coef_valid_s;
  assign coef_o       = coef_s;
  assign coef_idx_o   = coef_idx_r;
  assign poly_idx_o   = poly_idx_r;
  assign last_o       = coef_valid_s && poly_end_s && last_poly_s;
  assign busy_o       = sample_s;
  assign done_o       = (state_r == ST_FINISH);

endmodule

// File: tb/tb_cbd_sampler_stream.sv
// Self-checking bench for cbd_sampler_stream: randomized handshakes against a
// bit-stream CBD reference model.
module tb_cbd_sampler_stream;

  localparam int IN_W = 64, LANES = 4, COEFF_W = 8, MAX_POLY = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        eta = 1'b0;
  logic [3:0]  npoly = 4'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'd0;
  logic        coef_valid;
  logic        coef_ready = 1'b0;
  logic [31:0] coef;
  logic [7:0]  coef_idx;
  logic [2:0]  poly_idx;
  logic        last, busy, done;

  always #5 clk = ~clk;

  cbd_sampler_stream #(.IN_W(IN_W), .LANES(LANES), .COEFF_W(COEFF_W), .MAX_POLY(MAX_POLY)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .eta_i(eta), .npoly_i(npoly),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .coef_valid_o(coef_valid), .coef_ready_i(coef_ready), .coef_o(coef),
    .coef_idx_o(coef_idx), .poly_idx_o(poly_idx), .last_o(last),
    .busy_o(busy), .done_o(done)
  );

  int n_cmp = 0, n_fail = 0;
  logic [63:0] words_m [0:191];
  int got_c [0:2047];
  int beats, words_acc, last_cnt, last_beat, last_bad, idx_err, stall_err;
  int ready_excess, ready_seen, done_cyc, done_pulses, last_hs_cyc;
  bit timeout;

  // Reference: coefficient i of polynomial p straight from that polynomial's bit stream.
  function automatic int model_coef(input logic e, input int p, input int i);
    int w, base, a, b, n;
    w = e ? 3 : 2;
    base = p * (e ? 24 : 16) * 64 + 2 * w * i;
    a = 0; b = 0;
    for (int t = 0; t < w; t++) begin
      n = base + t;     a += int'(words_m[n / 64][n % 64]);
      n = base + w + t; b += int'(words_m[n / 64][n % 64]);
    end
    return a - b;
  endfunction

  function automatic int model_bad(input logic e, input int np);
    int bad = 0;
    for (int p = 0; p < np; p++)
      for (int i = 0; i < 256; i++)
        if (got_c[p * 256 + i] != model_coef(e, p, i)) bad++;
    return bad;
  endfunction

  task automatic run_stream(input logic e, input int np, input int vprob, input int rprob,
                            input int glitch_cyc, input int abort_beat);
    int wpp, total, cyc;
    logic [31:0] prev_coef;
    logic [7:0]  prev_idx;
    logic        prev_stall;
    wpp = e ? 24 : 16; total = wpp * np;
    beats = 0; words_acc = 0; last_cnt = 0; last_beat = 0; last_bad = 0; idx_err = 0;
    stall_err = 0; ready_excess = 0; ready_seen = 0; done_cyc = -1; done_pulses = 0;
    last_hs_cyc = -1; cyc = 0; prev_stall = 1'b0; prev_coef = '0; prev_idx = '0;
    for (int i = 0; i < 2048; i++) got_c[i] = 99;
    @(negedge clk); run = 1'b1; eta = e; npoly = 4'(np); in_valid = 1'b0; coef_ready = 1'b0;
    @(negedge clk); run = 1'b0;
    while (cyc < 6000) begin
      run = (cyc == glitch_cyc);
      if (run) begin eta = ~e; npoly = 4'(MAX_POLY); end
      if (abort_beat >= 0 && beats >= abort_beat) break;
      in_valid   = (words_acc < total) && ($urandom_range(99) < vprob);
      in_data    = in_valid ? words_m[words_acc] : {$urandom, $urandom};
      coef_ready = ($urandom_range(99) < rprob);
      if (done) begin done_pulses++; if (done_cyc < 0) done_cyc = cyc; end
      if (in_ready) ready_seen++;
      if (prev_stall && (coef_valid !== 1'b1 || coef !== prev_coef || coef_idx !== prev_idx)) stall_err++;
      if (in_ready && words_acc >= (beats / 64 + 1) * wpp) ready_excess++;
      if (last && !coef_valid) last_bad++;
      if (in_valid && in_ready) words_acc++;
      if (coef_valid && coef_ready) begin
        if (int'(coef_idx) != (beats % 64) * LANES || int'(poly_idx) != beats / 64) idx_err++;
        for (int k = 0; k < LANES; k++)
          if (beats * LANES + k < 2048) got_c[beats * LANES + k] = int'($signed(coef[k*COEFF_W +: COEFF_W]));
        if (last) begin last_cnt++; last_beat = beats + 1; end
        beats++; last_hs_cyc = cyc;
      end
      prev_stall = coef_valid && !coef_ready; prev_coef = coef; prev_idx = coef_idx;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0; coef_ready = 1'b0; run = 1'b0;
    timeout = (done_cyc < 0) && (abort_beat < 0);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (coef_valid !== 1'b0) begin n_fail++; $display("FAIL reset_coef_valid got=%b want=0", coef_valid); end
    n_cmp++; if (coef !== 32'd0)      begin n_fail++; $display("FAIL reset_coef got=%h want=0", coef); end
    n_cmp++; if (coef_idx !== 8'd0 || poly_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d/%0d want=0/0", coef_idx, poly_idx); end
    n_cmp++; if ({last, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b want=000", {last, busy, done}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_eta2_const();
    int non2 = 0;
    for (int i = 0; i < 16; i++) words_m[i] = 64'h3333_3333_3333_3333;
    run_stream(1'b0, 1, 100, 100, -1, -1);
    for (int i = 0; i < 256; i++) if (got_c[i] != 2) non2++;
    n_cmp++; if (timeout)         begin n_fail++; $display("FAIL eta2_const_timeout got=no done want=done"); end
    n_cmp++; if (beats != 64)     begin n_fail++; $display("FAIL eta2_const_beats got=%0d want=64", beats); end
    n_cmp++; if (words_acc != 16) begin n_fail++; $display("FAIL eta2_const_words got=%0d want=16", words_acc); end
    n_cmp++; if (non2 != 0)       begin n_fail++; $display("FAIL eta2_const_coef got=%0d wrong want=0 (all +2)", non2); end
    n_cmp++; if (last_cnt != 1 || last_beat != 64 || last_bad != 0)
      begin n_fail++; $display("FAIL eta2_const_last got=cnt%0d beat%0d bad%0d want=1/64/0", last_cnt, last_beat, last_bad); end
    n_cmp++; if (!(done_cyc - last_hs_cyc >= 1 && done_cyc - last_hs_cyc <= 2) || done_pulses != 1)
      begin n_fail++; $display("FAIL eta2_const_done got=gap%0d pulses%0d want=gap1..2 pulses1", done_cyc - last_hs_cyc, done_pulses); end
  endtask

  task automatic test_eta2_two_poly();
    int nonfe = 0;
    for (int i = 0; i < 32; i++) words_m[i] = 64'hCCCC_CCCC_CCCC_CCCC;
    run_stream(1'b0, 2, 100, 100, -1, -1);
    for (int i = 0; i < 512; i++) if (got_c[i] != -2) nonfe++;
    n_cmp++; if (beats != 128 || timeout) begin n_fail++; $display("FAIL two_poly_beats got=%0d want=128", beats); end
    n_cmp++; if (nonfe != 0)      begin n_fail++; $display("FAIL two_poly_coef got=%0d wrong want=0 (all -2)", nonfe); end
    n_cmp++; if (idx_err != 0)    begin n_fail++; $display("FAIL two_poly_idx got=%0d bad beats want=0", idx_err); end
    n_cmp++; if (words_acc != 32 || ready_excess != 0)
      begin n_fail++; $display("FAIL two_poly_words got=%0d excess%0d want=32 excess0", words_acc, ready_excess); end
    n_cmp++; if (last_beat != 128 || last_cnt != 1) begin n_fail++; $display("FAIL two_poly_last got=%0d want=128", last_beat); end
  endtask

  task automatic test_eta3_straddle();
    int others = 0;
    words_m[0] = 64'hF000_0000_0000_0007;
    for (int i = 1; i < 24; i++) words_m[i] = 64'd0;
    run_stream(1'b1, 1, 100, 100, -1, -1);
    for (int i = 1; i < 256; i++) if (i != 10 && got_c[i] != 0) others++;
    n_cmp++; if (got_c[0] != 3)   begin n_fail++; $display("FAIL straddle_c0 got=%0d want=3", got_c[0]); end
    n_cmp++; if (got_c[10] != 2)  begin n_fail++; $display("FAIL straddle_c10 got=%0d want=2", got_c[10]); end
    n_cmp++; if (others != 0)     begin n_fail++; $display("FAIL straddle_others got=%0d nonzero want=0", others); end
    n_cmp++; if (words_acc != 24 || ready_excess != 0 || timeout)
      begin n_fail++; $display("FAIL straddle_words got=%0d excess%0d want=24 excess0", words_acc, ready_excess); end
  endtask

  task automatic test_random_stream();
    int bad;
    for (int i = 0; i < 96; i++) words_m[i] = {$urandom, $urandom};
    run_stream(1'b1, 4, 70, 50, -1, -1);
    bad = model_bad(1'b1, 4);
    n_cmp++; if (bad != 0)        begin n_fail++; $display("FAIL rand_eta3_model got=%0d wrong want=0", bad); end
    n_cmp++; if (stall_err != 0)  begin n_fail++; $display("FAIL rand_eta3_stall got=%0d unstable want=0", stall_err); end
    n_cmp++; if (words_acc != 96 || ready_excess != 0)
      begin n_fail++; $display("FAIL rand_eta3_words got=%0d excess%0d want=96 excess0", words_acc, ready_excess); end
    n_cmp++; if (beats != 256 || idx_err != 0 || timeout)
      begin n_fail++; $display("FAIL rand_eta3_beats got=%0d idxerr%0d want=256/0", beats, idx_err); end
    n_cmp++; if (last_cnt != 1 || last_beat != 256) begin n_fail++; $display("FAIL rand_eta3_last got=%0d want=256", last_beat); end
    for (int i = 0; i < 48; i++) words_m[i] = {$urandom, $urandom};
    run_stream(1'b0, 3, 40, 60, -1, -1);
    bad = model_bad(1'b0, 3);
    n_cmp++; if (bad != 0 || stall_err != 0 || beats != 192)
      begin n_fail++; $display("FAIL rand_eta2_model got=bad%0d stall%0d beats%0d want=0/0/192", bad, stall_err, beats); end
  endtask

  task automatic test_zero_and_ignored_run();
    int bad;
    run_stream(1'b0, 0, 100, 100, -1, -1);
    n_cmp++; if (done_cyc != 0 || done_pulses != 1)
      begin n_fail++; $display("FAIL zero_done got=cyc%0d pulses%0d want=0/1", done_cyc, done_pulses); end
    n_cmp++; if (beats != 0 || ready_seen != 0)
      begin n_fail++; $display("FAIL zero_activity got=beats%0d ready%0d want=0/0", beats, ready_seen); end
    for (int i = 0; i < 16; i++) words_m[i] = {$urandom, $urandom};
    run_stream(1'b0, 1, 80, 70, 20, -1);
    bad = model_bad(1'b0, 1);
    n_cmp++; if (bad != 0 || beats != 64 || words_acc != 16 || timeout)
      begin n_fail++; $display("FAIL ignored_run got=bad%0d beats%0d words%0d want=0/64/16", bad, beats, words_acc); end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    for (int i = 0; i < 48; i++) words_m[i] = {$urandom, $urandom};
    run_stream(1'b1, 2, 100, 60, -1, 30);
    n_cmp++; if (beats != 30) begin n_fail++; $display("FAIL abort_reach got=%0d want=30", beats); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, coef_valid, last, busy, done, coef_idx, poly_idx, coef} !== '0)
      begin n_fail++; $display("FAIL abort_outputs got=%b%b%b%b%b %0d %0d %h want=all 0", in_ready, coef_valid, last, busy, done, coef_idx, poly_idx, coef); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) words_m[i] = {$urandom, $urandom};
    run_stream(1'b0, 1, 90, 80, -1, -1);
    bad = model_bad(1'b0, 1);
    n_cmp++; if (bad != 0 || idx_err != 0 || beats != 64 || words_acc != 16 || timeout)
      begin n_fail++; $display("FAIL after_reset got=bad%0d idxerr%0d beats%0d words%0d want=0/0/64/16", bad, idx_err, beats, words_acc); end
  endtask

  initial begin
    test_reset();
    test_eta2_const();
    test_eta2_two_poly();
    test_eta3_straddle();
    test_random_stream();
    test_zero_and_ignored_run();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
